// File: rtl/seg7_bcd_captura_pkg.sv
// Segment patterns (gfedcba, active-high) for the digits 0-9.
// The BCD->7-segment encoder uses the same constants, so the two tables cannot drift apart.
package seg7_bcd_captura_pkg;

    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;

    localparam logic [3:0] BCD_INVALIDO = 4'hF;

    typedef struct packed {
        logic       invalido;
        logic [3:0] bcd;
    } dec_t;

endpackage

// File: rtl/seg7_bcd_captura_dec.sv
// Combinational decoder: 7-segment pattern back to BCD.
// Any pattern that is not a digit, including a blank display, decodes as invalid.
module seg7_bcd_captura_dec
    import seg7_bcd_captura_pkg::*;
(
    input  logic [6:0] i_seg,
    output dec_t       o_dec
);

    always_comb begin
        o_dec.invalido = 1'b0;
        o_dec.bcd      = BCD_INVALIDO;
        case (i_seg)
            PAT_0:   o_dec.bcd = 4'd0;
            PAT_1:   o_dec.bcd = 4'd1;
            PAT_2:   o_dec.bcd = 4'd2;
            PAT_3:   o_dec.bcd = 4'd3;
            PAT_4:   o_dec.bcd = 4'd4;
            PAT_5:   o_dec.bcd = 4'd5;
            PAT_6:   o_dec.bcd = 4'd6;
            PAT_7:   o_dec.bcd = 4'd7;
            PAT_8:   o_dec.bcd = 4'd8;
            PAT_9:   o_dec.bcd = 4'd9;
            default: o_dec.invalido = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_captura.sv
// Captures a multiplexed 7-segment display bus back into BCD digits.
// A digit is captured once its pattern and anode have held for STABLE samples.
module seg7_bcd_captura
    import seg7_bcd_captura_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int STABLE       = 4,
    parameter bit ANODO_ACTIVO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segmentos,
    input  logic [DIGITS-1:0]     anodos,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valido,
    output logic [DIGITS-1:0]     err_patron,
    output logic                  err_anodo
);

    localparam int                CNT_W   = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE);
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;

    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_ano;
    logic [6:0]           r_seg_d;
    logic [DIGITS-1:0]    r_ano_d;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIGITS-1:0]    r_seen;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [DIGITS-1:0]    r_err;
    logic                 r_valido;
    logic                 r_err_anodo;

    logic [DIGITS-1:0]    w_ano_norm;
    logic                 w_multi;
    logic                 w_onehot;
    logic                 w_same;
    logic                 w_cap;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [DIGITS-1:0]    w_cap_mask;
    logic [DIGITS-1:0]    w_seen_nxt;
    dec_t                 w_dec;

    assign w_ano_norm = ANODO_ACTIVO ? anodos : ~anodos;

    // Input sample stage; r_*_d keep the previous sample for the dwell comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= '0;
            r_ano   <= '0;
            r_seg_d <= '0;
            r_ano_d <= '0;
        end else begin
            r_seg   <= segmentos;
            r_ano   <= w_ano_norm;
            r_seg_d <= r_seg;
            r_ano_d <= r_ano;
        end
    end

    seg7_bcd_captura_dec u_dec (
        .i_seg (r_seg),
        .o_dec (w_dec)
    );

    assign w_multi  = |(r_ano & (r_ano - DIGITS'(1)));
    assign w_onehot = (r_ano != '0) && !w_multi;
    assign w_same   = (r_seg == r_seg_d) && (r_ano == r_ano_d);

    always_comb begin
        w_cnt_nxt = '0;
        w_cap     = 1'b0;
        if (w_onehot) begin
            if (w_same) begin
                w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                w_cap     = (r_cnt == CNT_MAX - CNT_W'(1));
            end else begin
                w_cnt_nxt = CNT_W'(1);
                w_cap     = (STABLE == 1);
            end
        end
    end

    assign w_cap_mask = w_cap ? r_ano : '0;
    assign w_seen_nxt = r_seen | w_cap_mask;

    // Run counter, seen mask and the two single-cycle flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_seen      <= '0;
            r_valido    <= 1'b0;
            r_err_anodo <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_err_anodo <= w_multi;
            if (w_seen_nxt == ALL_SEEN) begin
                r_seen   <= '0;
                r_valido <= 1'b1;
            end else begin
                r_seen   <= w_seen_nxt;
                r_valido <= 1'b0;
            end
        end
    end

    // Per-digit slots hold their last capture until recaptured or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_err <= '0;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (w_cap_mask[k]) begin
                    r_bcd[4*k +: 4] <= w_dec.bcd;
                    r_err[k]        <= w_dec.invalido;
                end
            end
        end
    end

    assign bcd        = r_bcd;
    assign valido     = r_valido;
    assign err_patron = r_err;
    assign err_anodo  = r_err_anodo;

endmodule

// File: tb/tb_seg7_bcd_captura.sv
// Bench for seg7_bcd_captura: directed scenarios plus random dwells, all outputs
// compared every cycle against a run-length reference model.
module tb_seg7_bcd_captura;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [6:0]           segmentos = '0;
    logic [DIGITS-1:0]    anodos = '0;
    logic [4*DIGITS-1:0]  bcd;
    logic                 valido;
    logic [DIGITS-1:0]    err_patron;
    logic                 err_anodo;

    seg7_bcd_captura #(.DIGITS(DIGITS), .STABLE(STABLE), .ANODO_ACTIVO(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .segmentos  (segmentos),
        .anodos     (anodos),
        .bcd        (bcd),
        .valido     (valido),
        .err_patron (err_patron),
        .err_anodo  (err_anodo)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int n_val = 0;
    int n_ea  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: unbounded run length of identical one-hot samples
    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [4*DIGITS-1:0] exp_bcd = '0;
    logic [DIGITS-1:0]   exp_err = '0;
    logic                exp_val = 1'b0;
    logic                exp_ea  = 1'b0;
    logic [6:0]          m_s = '0, m_ps = '0;
    logic [DIGITS-1:0]   m_a = '0, m_pa = '0;
    int                  run = 0;
    int                  seen = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_bcd = '0; exp_err = '0; exp_val = 1'b0; exp_ea = 1'b0;
            m_s = '0; m_ps = '0; m_a = '0; m_pa = '0; run = 0; seen = 0;
        end else begin
            int nact;
            nact    = $countones(m_a);
            exp_val = 1'b0;
            exp_ea  = (nact > 1);
            if (nact == 1) run = (m_s == m_ps && m_a == m_pa) ? run + 1 : 1;
            else           run = 0;
            if (nact == 1 && run == STABLE) begin
                int k, v;
                k = 0;
                for (int i = 0; i < DIGITS; i++) if (m_a[i]) k = i;
                v = -1;
                for (int d = 0; d < 10; d++) if (lut[d] == m_s) v = d;
                exp_bcd[4*k +: 4] = (v < 0) ? 4'hF : 4'(v);
                exp_err[k]        = (v < 0);
                seen = seen | (1 << k);
                if (seen == (1 << DIGITS) - 1) begin
                    exp_val = 1'b1;
                    seen    = 0;
                end
            end
            m_ps = m_s; m_pa = m_a;
            m_s  = segmentos; m_a = anodos;
        end
    end

    always @(negedge clk) begin
        chk("bcd", 32'(bcd), 32'(exp_bcd));
        chk("err_patron", 32'(err_patron), 32'(exp_err));
        chk("valido", 32'(valido), 32'(exp_val));
        chk("err_anodo", 32'(err_anodo), 32'(exp_ea));
        if (valido)    n_val++;
        if (err_anodo) n_ea++;
    end

    task automatic drive(input logic [6:0] s, input logic [DIGITS-1:0] a, input int n);
        segmentos = s;
        anodos    = a;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int dwell);
        drive(p0, 4'b0001, dwell);
        drive(p1, 4'b0010, dwell);
        drive(p2, 4'b0100, dwell);
        drive(p3, 4'b1000, dwell);
        drive(7'h00, 4'b0000, 3);
    endtask

    initial begin
        // Reset with a random bus
        rst = 1'b1;
        @(posedge clk); #1;
        segmentos = 7'($urandom); anodos = 4'($urandom);
        @(posedge clk); #1;
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_val", 32'(valido), 32'h0);
        chk("rst_errp", 32'(err_patron), 32'h0);
        chk("rst_erra", 32'(err_anodo), 32'h0);
        rst = 1'b0;
        drive(7'h00, 4'b0000, 4);
        chk("idle_bcd", 32'(bcd), 32'h0);

        // Full scan, dwell 8; valido on digit-3 capture edge
        n_val = 0;
        drive(7'h06, 4'b0001, 8);
        drive(7'h5B, 4'b0010, 8);
        drive(7'h4F, 4'b0100, 8);
        drive(7'h66, 4'b1000, 4);
        chk("scan_noval_yet", 32'(n_val), 32'd0);
        drive(7'h66, 4'b1000, 1);
        chk("scan_val_edge", 32'(valido), 32'd1);
        drive(7'h66, 4'b1000, 3);
        drive(7'h00, 4'b0000, 3);
        chk("scan_bcd", 32'(bcd), 32'h4321);
        chk("scan_nval", 32'(n_val), 32'd1);
        chk("scan_errp", 32'(err_patron), 32'h0);

        // Dwell 3 too short, dwell 4 captures
        n_val = 0;
        scan(7'h6D, 7'h7D, 7'h07, 7'h7F, 3);
        chk("d3_bcd", 32'(bcd), 32'h4321);
        chk("d3_nval", 32'(n_val), 32'd0);
        scan(7'h6D, 7'h7D, 7'h07, 7'h7F, 4);
        chk("d4_bcd", 32'(bcd), 32'h8765);
        chk("d4_nval", 32'(n_val), 32'd1);

        // Invalid pattern on digit 2, then corrected
        n_val = 0;
        scan(7'h06, 7'h5B, 7'h77, 7'h66, 6);
        chk("inv_bcd", 32'(bcd), 32'h4F21);
        chk("inv_errp", 32'(err_patron), 32'b0100);
        chk("inv_nval", 32'(n_val), 32'd1);
        scan(7'h06, 7'h5B, 7'h7D, 7'h66, 6);
        chk("fix_bcd", 32'(bcd), 32'h4621);
        chk("fix_errp", 32'(err_patron), 32'b0000);

        // Two anodes active
        n_val = 0; n_ea = 0;
        drive(7'h3F, 4'b0011, 6);
        drive(7'h00, 4'b0000, 3);
        chk("multi_nea", 32'(n_ea), 32'd6);
        chk("multi_nval", 32'(n_val), 32'd0);
        chk("multi_bcd", 32'(bcd), 32'h4621);

        // Pattern change restarts the dwell
        drive(7'h06, 4'b0001, 2);
        drive(7'h3F, 4'b0001, 5);
        drive(7'h00, 4'b0000, 2);
        chk("restart_bcd", 32'(bcd), 32'h4620);

        // Reset mid-frame discards seen digits
        drive(7'h5B, 4'b0010, 6);
        rst = 1'b1;
        drive(7'h00, 4'b0000, 1);
        rst = 1'b0;
        chk("midrst_bcd", 32'(bcd), 32'h0);
        n_val = 0;
        drive(7'h5B, 4'b0100, 6);
        drive(7'h4F, 4'b1000, 6);
        drive(7'h00, 4'b0000, 3);
        chk("midrst_half", 32'(n_val), 32'd0);
        drive(7'h3F, 4'b0001, 6);
        drive(7'h06, 4'b0010, 6);
        drive(7'h00, 4'b0000, 3);
        chk("midrst_full", 32'(n_val), 32'd1);
        chk("midrst_bcd2", 32'(bcd), 32'h3210);

        // Random dwells checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            logic [6:0]        s;
            logic [DIGITS-1:0] a;
            int                sel;
            s   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : lut[$urandom_range(0, 9)];
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = '0;
            else if (sel == 1) a = 4'($urandom);
            else               a = 4'(1 << $urandom_range(0, DIGITS - 1));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                drive(s, a, 1);
                rst = 1'b0;
            end
            drive(s, a, $urandom_range(1, 8));
        end
        drive(7'h00, 4'b0000, 3);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
